// File: rtl/softplus8_pkg.sv
// softplus8 shared constants: Q8.8 format, inverse-softplus PLA tables,
// forward-softplus constants and the inter-stage bundles.
package softplus8_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 8;
    localparam int SEG_N  = 8;
    localparam int SEG_KW = 3;

    typedef logic [Q_W-1:0]        uq_t;
    typedef logic signed [Q_W-1:0] sq_t;
    typedef logic [SEG_KW-1:0]     seg_k_t;

    // inverse softplus: segment starts, start values, slopes (Q8.8)
    localparam uq_t INV_Y0 [SEG_N] = '{
        16'd1, 16'd32, 16'd64, 16'd128,
        16'd256, 16'd384, 16'd512, 16'd768
    };
    localparam sq_t INV_X0 [SEG_N] = '{
        -16'sd1419, -16'sd516, -16'sd322, -16'sd111,
        16'sd139, 16'sd319, 16'sd475, 16'sd755
    };
    localparam uq_t INV_S [SEG_N] = '{
        16'd7457, 16'd1552, 16'd844, 16'd500,
        16'd360, 16'd312, 16'd280, 16'd260
    };

    // above this y, ln(e^y - 1) equals y to within an LSB
    localparam uq_t INV_ID_LO = 16'd1536;

    // forward softplus: identity above 6.0, ~0 below -6.0,
    // softplus(0) = ln 2
    localparam sq_t FWD_ID_X   = 16'sd1536;
    localparam sq_t FWD_ZERO_X = -16'sd1536;
    localparam uq_t FWD_Y_AT_0 = 16'd177;

    typedef struct packed {
        logic   valid;
        seg_k_t k;
        uq_t    off;
        logic   zero;
        logic   ident;
        logic   hi;
    } inv_s1_t;

    typedef struct packed {
        logic valid;
        sq_t  x;
        logic sat;
    } inv_s2_t;

endpackage

// File: rtl/softplus8_inv_seg.sv
// softplus8 inverse segment lookup: y -> segment, start point, flags,
// plus the X0/S table read for the segment held in stage 1.
import softplus8_pkg::*;

module softplus8_inv_seg (
    input  logic [15:0]        y,
    output logic [2:0]         k,
    output logic [15:0]        y0,
    output logic               zero,
    output logic               ident,
    output logic               hi,
    input  logic [2:0]         lut_k,
    output logic signed [15:0] lut_x0,
    output logic [15:0]        lut_s
);

    // largest segment whose start is <= y; special ranges use y0 = 0
    always_comb begin
        k = '0;
        for (int i = 1; i < SEG_N; i++) begin
            if (y >= INV_Y0[i]) k = 3'(i);
        end
        zero  = (y == '0);
        hi    = y[15];
        ident = !y[15] && (y >= INV_ID_LO);
        y0    = (zero || ident || hi) ? '0 : INV_Y0[k];
    end

    // start value and slope of the registered segment
    always_comb begin
        lut_x0 = INV_X0[lut_k];
        lut_s  = INV_S[lut_k];
    end

endmodule

// File: rtl/softplus8_inv_pla.sv
// softplus8 inverse: two-stage PLA x = ln(e^y - 1) in Q8.8 with
// valid/ready handshake and saturation flag.
import softplus8_pkg::*;

module softplus8_inv_pla (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x,
    output logic        x_sat
);

    inv_s1_t s1_q, s1_d;
    inv_s2_t s2_q, s2_d;

    logic               adv;
    logic [2:0]         seg_k;
    logic [15:0]        seg_y0;
    logic               seg_zero;
    logic               seg_ident;
    logic               seg_hi;
    logic signed [15:0] lut_x0;
    logic [15:0]        lut_s;
    logic signed [31:0] prod;
    logic signed [31:0] seg_x;

    softplus8_inv_seg u_seg (
        .y      (y),
        .k      (seg_k),
        .y0     (seg_y0),
        .zero   (seg_zero),
        .ident  (seg_ident),
        .hi     (seg_hi),
        .lut_k  (s1_q.k),
        .lut_x0 (lut_x0),
        .lut_s  (lut_s)
    );

    // whole pipe moves together unless the output is stalled
    always_comb begin
        adv       = !s2_q.valid || out_ready;
        in_ready  = adv;
        out_valid = s2_q.valid;
        x         = s2_q.x;
        x_sat     = s2_q.sat;
    end

    // stage 1: capture segment, offset and range flags
    always_comb begin
        s1_d = s1_q;
        if (adv) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                s1_d.k     = seg_k;
                s1_d.off   = y - seg_y0;
                s1_d.zero  = seg_zero;
                s1_d.ident = seg_ident;
                s1_d.hi    = seg_hi;
            end
        end
    end

    // stage 2: linear segment, range overrides and clamping
    always_comb begin
        prod  = $signed({16'd0, s1_q.off}) * $signed({16'd0, lut_s});
        seg_x = $signed({{16{lut_x0[15]}}, lut_x0}) + (prod >>> Q_FRAC);
        s2_d  = s2_q;
        if (adv) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.sat = 1'b0;
                if (s1_q.zero) begin
                    s2_d.x   = 16'sh8000;
                    s2_d.sat = 1'b1;
                end else if (s1_q.hi) begin
                    s2_d.x   = 16'sh7fff;
                    s2_d.sat = 1'b1;
                end else if (s1_q.ident) begin
                    s2_d.x = s1_q.off;
                end else if (seg_x > 32'sd32767) begin
                    s2_d.x   = 16'sh7fff;
                    s2_d.sat = 1'b1;
                end else if (seg_x < -32'sd32768) begin
                    s2_d.x   = 16'sh8000;
                    s2_d.sat = 1'b1;
                end else begin
                    s2_d.x = seg_x[15:0];
                end
            end
        end
    end

    // pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

endmodule

// File: tb/tb_softplus8_inv_pla.sv
// softplus8_inv_pla bench: directed vectors with hand-computed results,
// handshake scenarios and a reference sweep.
module tb_softplus8_inv_pla;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] x;
    logic        x_sat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_in = 0;
    int n_out = 0;
    bit chk_lat = 1'b0;
    int q_x[$];
    bit q_s[$];
    int q_c[$];

    softplus8_inv_pla dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .x_sat     (x_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step(input bit iv, input logic [15:0] yv,
                        input int ex, input bit es, input bit ordy);
        in_valid  = iv;
        y         = yv;
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) begin
            q_x.push_back(ex);
            q_s.push_back(es);
            q_c.push_back(cyc);
            n_in++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (q_x.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out x=%0d want none",
                         $signed(x));
            end else begin
                int ex2;
                bit es2;
                int c;
                ex2 = q_x.pop_front();
                es2 = q_s.pop_front();
                c   = q_c.pop_front();
                if (x !== ex2[15:0] || x_sat !== es2) begin
                    failures++;
                    $display("FAIL out_value got x=%0d sat=%0b want x=%0d sat=%0b",
                             $signed(x), x_sat, ex2, es2);
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc - c != 2) begin
                        failures++;
                        $display("FAIL latency got %0d want 2", cyc - c);
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 0, 1'b0, 1'b1);
        checks++;
        if (q_x.size() != 0) begin
            failures++;
            $display("FAIL drain_left got %0d want 0", q_x.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got %0b want 0", out_valid);
        end
        if (x !== 16'd0) begin
            failures++;
            $display("FAIL rst_x got %0d want 0", x);
        end
        if (x_sat !== 1'b0) begin
            failures++;
            $display("FAIL rst_x_sat got %0b want 0", x_sat);
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_ready got %0b want 1", in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_in_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_stream();
        chk_lat = 1'b1;
        step(1'b1, 16'd0,    -32768, 1'b1, 1'b1);
        step(1'b1, 16'd128,  -111,   1'b0, 1'b1);
        step(1'b1, 16'd256,  139,    1'b0, 1'b1);
        step(1'b1, 16'd512,  475,    1'b0, 1'b1);
        step(1'b1, 16'd768,  755,    1'b0, 1'b1);
        step(1'b1, 16'd1792, 1792,   1'b0, 1'b1);
        drain(3);
        chk_lat = 1'b0;
    endtask

    task automatic test_seg_starts();
        step(1'b1, 16'd1,    -1419, 1'b0, 1'b1);
        step(1'b1, 16'd32,   -516,  1'b0, 1'b1);
        step(1'b1, 16'd64,   -322,  1'b0, 1'b1);
        step(1'b1, 16'd384,  319,   1'b0, 1'b1);
        step(1'b1, 16'd31,   -546,  1'b0, 1'b1);
        step(1'b1, 16'd255,  137,   1'b0, 1'b1);
        step(1'b1, 16'd1535, 1533,  1'b0, 1'b1);
        drain(3);
    endtask

    task automatic test_upper();
        step(1'b1, 16'd1536,  1536,  1'b0, 1'b1);
        step(1'b1, 16'd40000, 32767, 1'b1, 1'b1);
        step(1'b1, 16'd32767, 32767, 1'b0, 1'b1);
        step(1'b1, 16'd32768, 32767, 1'b1, 1'b1);
        drain(3);
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        logic [15:0] ys [6];
        int xs [6];
        ys = '{16'd256, 16'd512, 16'd768, 16'd1792, 16'd384, 16'd128};
        xs = '{139, 475, 755, 1792, 319, -111};
        n_in  = 0;
        n_out = 0;
        step(1'b1, ys[0], xs[0], 1'b0, 1'b0);
        step(1'b1, ys[1], xs[1], 1'b0, 1'b0);
        held = x;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            y         = ys[2];
            out_ready = 1'b0;
            #1;
            checks += 2;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready got %0b want 0", in_ready);
            end
            if (x !== held || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold got x=%0d v=%0b want x=%0d v=1",
                         $signed(x), out_valid, $signed(held));
            end
            step(1'b1, ys[2], xs[2], 1'b0, 1'b0);
        end
        for (int i = 2; i < 6; i++) step(1'b1, ys[i], xs[i], 1'b0, 1'b1);
        drain(4);
        checks++;
        if (n_in != 6 || n_out != 6) begin
            failures++;
            $display("FAIL bp_count got in=%0d out=%0d want 6/6",
                     n_in, n_out);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'd256, 139, 1'b0, 1'b1);
        step(1'b1, 16'd512, 475, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_valid got %0b want 0", out_valid);
        end
        if (x !== 16'd0 || x_sat !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_x got %0d/%0b want 0/0", x, x_sat);
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_in_ready got %0b want 1", in_ready);
        end
        q_x.delete();
        q_s.delete();
        q_c.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL stale_out got v=%0b x=%0d want v=0",
                         out_valid, $signed(x));
            end
            step(1'b0, 16'd0, 0, 1'b0, 1'b1);
        end
        step(1'b1, 16'd768, 755, 1'b0, 1'b1);
        drain(3);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] yv;
            bit got;
            real r;
            real err;
            yv        = 16'($urandom_range(1535, 32));
            in_valid  = 1'b1;
            y         = yv;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                if (out_valid) got = 1'b1;
                else begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL sweep_timeout y=%0d got none want result", yv);
            end else begin
                r   = $ln($exp(real'(yv) / 256.0) - 1.0) * 256.0;
                err = real'(int'($signed(x))) - r;
                if (err < 0.0) err = -err;
                if (err > 16.0 || x_sat !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep y=%0d got x=%0d sat=%0b want %f",
                             yv, $signed(x), x_sat, r);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_seg_starts();
        test_upper();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
